game_round_sequencer: RTL and testbench
=======================================

GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

Interface
REQ-001 Parameter ROUND_TICKS, default 8'd30, CEN ticks allowed per round.
REQ-002 Parameter MAX_LIVES, default 2'd3, lives granted per game (legal range 1..3).
REQ-003 Clk  input  1  system clock; all logic rises on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 CEN  input  1  timer tick enable, one-cycle pulse.
REQ-006 Start  input  1  one-cycle pulse, begins a game.
REQ-007 Select  input  1  one-cycle pulse, submits the answer.
REQ-008 Quit  input  1  one-cycle pulse, abandons the game.
REQ-009 rndNumber  input  8  free-running random value from the number generator.
REQ-010 userNumber  input  8  switch value entered by the player.
REQ-011 outputNumber  output  8  target number for the current round (registered).
REQ-012 roundTimer  output  8  remaining ticks in the current round.
REQ-013 playerScore  output  8  correct answers in the current game.
REQ-014 highScore  output  8  best playerScore since Reset.
REQ-015 livesLeft  output  2  remaining lives.
REQ-016 isWrong  output  1  result of the last evaluated round.
REQ-017 state  output  6  one-hot state vector {OVER,MISS,HIT,ANSWER,LOAD,IDLE}, MSB first.

Function
REQ-018 The block SHALL be a one-hot FSM with states IDLE, LOAD, ANSWER, HIT, MISS and OVER. Any illegal encoding SHALL go to IDLE on the next cycle.
REQ-019 IDLE: on Start, the block SHALL clear playerScore, set livesLeft=MAX_LIVES, clear isWrong and go to LOAD; otherwise it SHALL hold.
REQ-020 LOAD: the block SHALL last exactly one cycle, latch rndNumber into outputNumber, set roundTimer=ROUND_TICKS and go to ANSWER.
REQ-021 ANSWER: event priority SHALL be Quit > Select > timeout, evaluated every cycle regardless of CEN.
- Quit: go to OVER.
- Select with userNumber==outputNumber: isWrong<=0, go to HIT.
- Select with a mismatch: isWrong<=1, go to MISS.
REQ-022 ANSWER: on CEN with roundTimer>0, roundTimer SHALL decrement by 1. On CEN with roundTimer==0 and no Quit/Select, the block SHALL set isWrong<=1 and go to MISS.
REQ-023 HIT: the block SHALL last one cycle, increment playerScore saturating at 255, and go to LOAD.
REQ-024 MISS: the block SHALL last one cycle. If livesLeft==1, livesLeft<=0 and go to OVER; otherwise livesLeft decrements by 1 and the block goes to LOAD.
REQ-025 OVER entry cycle: highScore SHALL update to playerScore if playerScore>highScore. OVER SHALL hold until Select, then go to IDLE.
REQ-026 playerScore, livesLeft and outputNumber SHALL hold their values in OVER and IDLE until the next Start.
REQ-027 Start SHALL be ignored outside IDLE. Select/Quit SHALL be ignored in LOAD, HIT and MISS. Quit SHALL be ignored in IDLE and OVER.
REQ-028 Latency: Select in ANSWER to the new outputNumber SHALL be 3 cycles (ANSWER→HIT→LOAD→ANSWER, value valid on ANSWER entry).

Reset
REQ-029 Reset SHALL force state=IDLE, outputNumber=0, roundTimer=0, playerScore=0, highScore=0, livesLeft=0 and isWrong=0.
REQ-030 Reset SHALL take priority over all other inputs, including mid-round, and SHALL clear highScore.

Configuration
REQ-031 Macro GAME_ROUND_TIMEOUT_EN. When defined, the round timer of REQ-020/REQ-022 SHALL be compiled in.
REQ-032 When GAME_ROUND_TIMEOUT_EN is undefined, there SHALL be no timer logic. roundTimer SHALL be tied to 0, CEN SHALL be ignored, and ANSWER SHALL wait indefinitely for Quit or Select.

Verification
REQ-033 Reset; Start; rndNumber=8'h5A at LOAD; userNumber=8'h5A; Select → HIT, playerScore=1, isWrong=0, new outputNumber on ANSWER re-entry 3 cycles later.
REQ-034 MAX_LIVES=3; three wrong Selects (userNumber≠outputNumber) → livesLeft 2,1,0, isWrong=1, state=OVER after the third MISS.
REQ-035 GAME_ROUND_TIMEOUT_EN defined, ROUND_TICKS=4; no Select; 5 CEN pulses → MISS on the 5th pulse, livesLeft decremented, roundTimer reloaded to 4.
REQ-036 Score 3, Quit in ANSWER → OVER, highScore=3. Next game scores 1 and Quit → highScore stays 3.
REQ-037 Select and Quit asserted in the same ANSWER cycle → OVER, playerScore unchanged. Reset asserted in ANSWER → all outputs at reset values on the next cycle.
REQ-038 playerScore=255 plus a correct Select → playerScore stays 255.

Source files
------------

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: one-hot round FSM for a number-guessing game; round timer compiled in only with GAME_ROUND_TIMEOUT_EN
module game_round_sequencer #(
   parameter logic [7:0] ROUND_TICKS = 8'd30,
   parameter logic [1:0] MAX_LIVES   = 2'd3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       CEN,
   input  logic       Start,
   input  logic       Select,
   input  logic       Quit,
   input  logic [7:0] rndNumber,
   input  logic [7:0] userNumber,
   output logic [7:0] outputNumber,
   output logic [7:0] roundTimer,
   output logic [7:0] playerScore,
   output logic [7:0] highScore,
   output logic [1:0] livesLeft,
   output logic       isWrong,
   output logic [5:0] state
);
   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      LOAD   = 6'b000010,
      ANSWER = 6'b000100,
      HIT    = 6'b001000,
      MISS   = 6'b010000,
      OVER   = 6'b100000
   } state_t;
   state_t     state_q;
   logic [7:0] num_q, score_q, high_q;
   logic [1:0] lives_q;
   logic       wrong_q;
   logic [7:0] best_d, score_d;
`ifdef GAME_ROUND_TIMEOUT_EN
   logic [7:0] timer_q;
   assign roundTimer = timer_q;
`else
   logic unused_cen;
   assign unused_cen = CEN ^ (|ROUND_TICKS);
   assign roundTimer = 8'd0;
`endif
   assign best_d       = (score_q > high_q) ? score_q : high_q;
   assign score_d      = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
   assign outputNumber = num_q;
   assign playerScore  = score_q;
   assign highScore    = high_q;
   assign livesLeft    = lives_q;
   assign isWrong      = wrong_q;
   assign state        = state_q;
   // Round sequencing; highScore is folded in on every transition into OVER
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         num_q   <= 8'd0;
         score_q <= 8'd0;
         high_q  <= 8'd0;
         lives_q <= 2'd0;
         wrong_q <= 1'b0;
`ifdef GAME_ROUND_TIMEOUT_EN
         timer_q <= 8'd0;
`endif
      end else begin
         case (state_q)
            IDLE: if (Start) begin
               score_q <= 8'd0;
               lives_q <= MAX_LIVES;
               wrong_q <= 1'b0;
               state_q <= LOAD;
            end
            LOAD: begin
               num_q   <= rndNumber;
`ifdef GAME_ROUND_TIMEOUT_EN
               timer_q <= ROUND_TICKS;
`endif
               state_q <= ANSWER;
            end
            ANSWER: begin
               if (Quit) begin
                  high_q  <= best_d;
                  state_q <= OVER;
               end else if (Select) begin
                  wrong_q <= userNumber != num_q;
                  state_q <= (userNumber == num_q) ? HIT : MISS;
               end
`ifdef GAME_ROUND_TIMEOUT_EN
               else if (CEN && timer_q == 8'd0) begin
                  wrong_q <= 1'b1;
                  state_q <= MISS;
               end else if (CEN) timer_q <= timer_q - 8'd1;
`endif
            end
            HIT: begin
               score_q <= score_d;
               state_q <= LOAD;
            end
            MISS: begin
               lives_q <= lives_q - 2'd1;
               if (lives_q == 2'd1) high_q <= best_d;
               state_q <= (lives_q == 2'd1) ? OVER : LOAD;
            end
            OVER: if (Select) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_game_round_sequencer.sv
// tb_game_round_sequencer: scenario tasks with an outputNumber scoreboard for game_round_sequencer
module tb_game_round_sequencer;
   localparam logic [5:0] S_IDLE = 6'b000001, S_LOAD = 6'b000010, S_ANSWER = 6'b000100;
   localparam logic [5:0] S_HIT = 6'b001000, S_MISS = 6'b010000, S_OVER = 6'b100000;
`ifdef GAME_ROUND_TIMEOUT_EN
   localparam logic [7:0] T_EXP = 8'd4;
`else
   localparam logic [7:0] T_EXP = 8'd0;
`endif
   logic       Clk = 1'b0;
   logic       Reset = 1'b1, CEN = 1'b0, Start = 1'b0, Select = 1'b0, Quit = 1'b0;
   logic [7:0] rndNumber = 8'd0, userNumber = 8'd0;
   logic [7:0] outputNumber, roundTimer, playerScore, highScore;
   logic [1:0] livesLeft;
   logic       isWrong;
   logic [5:0] state;
   logic [7:0] exp_q[$];
   logic [7:0] exp_num;
   int passed = 0, total = 0;

   game_round_sequencer #(.ROUND_TICKS(8'd4), .MAX_LIVES(2'd3)) dut (
      .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Select(Select), .Quit(Quit),
      .rndNumber(rndNumber), .userNumber(userNumber), .outputNumber(outputNumber),
      .roundTimer(roundTimer), .playerScore(playerScore), .highScore(highScore),
      .livesLeft(livesLeft), .isWrong(isWrong), .state(state)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(negedge Clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1; step(); step(); Reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic start_game();
      Start = 1'b1; step(); Start = 1'b0;
   endtask

   // LOAD cycle: drive the random value, record it, compare on ANSWER entry
   task automatic load_round(input logic [7:0] r);
      rndNumber = r; exp_q.push_back(r); step();
      exp_num = exp_q.pop_front();
      total++;
      if (state !== S_ANSWER || outputNumber !== exp_num || roundTimer !== T_EXP)
         $display("FAIL load_round: state %b num %h timer %0d, want %b %h %0d", state, outputNumber, roundTimer, S_ANSWER, exp_num, T_EXP);
      else passed++;
   endtask

   task automatic answer(input logic [7:0] u, input logic sel, input logic q);
      userNumber = u; Select = sel; Quit = q; step(); Select = 1'b0; Quit = 1'b0;
   endtask

   task automatic hit_round(input logic [7:0] r);
      load_round(r); answer(r, 1'b1, 1'b0); step();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b1; Select = 1'b1; Quit = 1'b1; CEN = 1'b1; rndNumber = 8'hEE;
      step(); step();
      Reset = 1'b0; Start = 1'b0; Select = 1'b0; Quit = 1'b0; CEN = 1'b0;
      total++;
      if (state !== S_IDLE) $display("FAIL reset_state: got %b want %b", state, S_IDLE); else passed++;
      total++;
      if ({outputNumber, roundTimer, playerScore, highScore, livesLeft, isWrong} !== 35'd0)
         $display("FAIL reset_outputs: num %h tmr %h sc %h hi %h lv %0d wr %b, want all 0", outputNumber, roundTimer, playerScore, highScore, livesLeft, isWrong);
      else passed++;
      answer(8'h00, 1'b1, 1'b1);
      total++;
      if (state !== S_IDLE) $display("FAIL idle_ignores_sel_quit: got %b want %b", state, S_IDLE); else passed++;
   endtask

   task automatic test_hit();
      do_reset(); start_game();
      total++;
      if (state !== S_LOAD || livesLeft !== 2'd3 || playerScore !== 8'd0 || isWrong !== 1'b0)
         $display("FAIL start: state %b lives %0d score %0d wrong %b, want %b 3 0 0", state, livesLeft, playerScore, isWrong, S_LOAD);
      else passed++;
      load_round(8'h5A);
      answer(8'h5A, 1'b1, 1'b0);
      total++;
      if (state !== S_HIT || isWrong !== 1'b0) $display("FAIL hit_enter: state %b wrong %b, want %b 0", state, isWrong, S_HIT); else passed++;
      Quit = 1'b1; step(); Quit = 1'b0;
      total++;
      if (state !== S_LOAD || playerScore !== 8'd1) $display("FAIL hit_score: state %b score %0d, want %b 1", state, playerScore, S_LOAD); else passed++;
      Select = 1'b1; Quit = 1'b1; userNumber = 8'h00;
      load_round(8'hC3);
      Select = 1'b0; Quit = 1'b0;
   endtask

   task automatic test_miss_lives();
      do_reset(); start_game();
      for (int i = 0; i < 3; i++) begin
         load_round(8'h10 + 8'(i));
         answer(8'h99, 1'b1, 1'b0);
         total++;
         if (state !== S_MISS || isWrong !== 1'b1) $display("FAIL miss_enter%0d: state %b wrong %b, want %b 1", i, state, isWrong, S_MISS); else passed++;
         step();
         total++;
         if (livesLeft !== 2'(2 - i) || state !== (i < 2 ? S_LOAD : S_OVER))
            $display("FAIL miss_lives%0d: lives %0d state %b, want %0d %b", i, livesLeft, state, 2 - i, (i < 2 ? S_LOAD : S_OVER));
         else passed++;
      end
   endtask

   task automatic test_over();
      start_game(); answer(8'h00, 1'b0, 1'b1);
      total++;
      if (state !== S_OVER || livesLeft !== 2'd0 || highScore !== 8'd0)
         $display("FAIL over_hold: state %b lives %0d hi %0d, want %b 0 0", state, livesLeft, highScore, S_OVER);
      else passed++;
      answer(8'h00, 1'b1, 1'b0);
      total++;
      if (state !== S_IDLE || outputNumber !== 8'h12 || livesLeft !== 2'd0 || isWrong !== 1'b1)
         $display("FAIL over_exit: state %b num %h lives %0d wrong %b, want %b 12 0 1", state, outputNumber, livesLeft, isWrong, S_IDLE);
      else passed++;
   endtask

   task automatic test_highscore();
      do_reset(); start_game();
      for (int i = 0; i < 3; i++) hit_round(8'h30 + 8'(i));
      load_round(8'h40);
      answer(8'h00, 1'b0, 1'b1);
      step();
      total++;
      if (state !== S_OVER || playerScore !== 8'd3 || highScore !== 8'd3)
         $display("FAIL hs_first: state %b score %0d hi %0d, want %b 3 3", state, playerScore, highScore, S_OVER);
      else passed++;
      answer(8'h00, 1'b1, 1'b0); start_game();
      total++;
      if (playerScore !== 8'd0 || highScore !== 8'd3) $display("FAIL hs_newgame: score %0d hi %0d, want 0 3", playerScore, highScore); else passed++;
      hit_round(8'h07); load_round(8'h08);
      answer(8'h00, 1'b0, 1'b1);
      step();
      total++;
      if (playerScore !== 8'd1 || highScore !== 8'd3) $display("FAIL hs_keep: score %0d hi %0d, want 1 3", playerScore, highScore); else passed++;
   endtask

   task automatic test_select_quit();
      answer(8'h00, 1'b1, 1'b0); start_game();
      hit_round(8'h21); load_round(8'h22);
      answer(8'h22, 1'b1, 1'b1);
      total++;
      if (state !== S_OVER || playerScore !== 8'd1 || isWrong !== 1'b0)
         $display("FAIL sel_quit: state %b score %0d wrong %b, want %b 1 0", state, playerScore, isWrong, S_OVER);
      else passed++;
   endtask

   task automatic test_reset_mid();
      answer(8'h00, 1'b1, 1'b0); start_game(); load_round(8'h77);
      Reset = 1'b1; Select = 1'b1; userNumber = 8'h77; step(); Reset = 1'b0; Select = 1'b0;
      exp_q.delete();
      total++;
      if (state !== S_IDLE || {outputNumber, roundTimer, playerScore, highScore, livesLeft, isWrong} !== 35'd0)
         $display("FAIL reset_mid: state %b num %h sc %0d hi %0d lv %0d wr %b, want %b all 0", state, outputNumber, playerScore, highScore, livesLeft, isWrong, S_IDLE);
      else passed++;
   endtask

   task automatic test_timer();
      start_game(); load_round(8'h50);
`ifdef GAME_ROUND_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         CEN = 1'b1; step(); CEN = 1'b0;
         total++;
         if (state !== S_ANSWER || roundTimer !== 8'(3 - k)) $display("FAIL timer_dec%0d: state %b tmr %0d, want %b %0d", k, state, roundTimer, S_ANSWER, 3 - k); else passed++;
      end
      CEN = 1'b1; step(); CEN = 1'b0;
      total++;
      if (state !== S_MISS || isWrong !== 1'b1) $display("FAIL timeout: state %b wrong %b, want %b 1", state, isWrong, S_MISS); else passed++;
      step();
      total++;
      if (state !== S_LOAD || livesLeft !== 2'd2) $display("FAIL timeout_lives: state %b lives %0d, want %b 2", state, livesLeft, S_LOAD); else passed++;
      load_round(8'h51);
`else
      for (int k = 0; k < 40; k++) begin
         CEN = 1'b1; step(); CEN = 1'b0;
      end
      total++;
      if (state !== S_ANSWER || roundTimer !== 8'd0 || livesLeft !== 2'd3)
         $display("FAIL no_timer: state %b tmr %0d lives %0d, want %b 0 3", state, roundTimer, livesLeft, S_ANSWER);
      else passed++;
`endif
   endtask

   task automatic test_saturate();
      do_reset(); start_game();
      for (int i = 0; i < 256; i++) hit_round(8'(i));
      total++;
      if (playerScore !== 8'd255) $display("FAIL sat_reach: score %0d, want 255", playerScore); else passed++;
      load_round(8'hAB); answer(8'hAB, 1'b1, 1'b0); step();
      total++;
      if (state !== S_LOAD || playerScore !== 8'd255) $display("FAIL sat_hold: state %b score %0d, want %b 255", state, playerScore, S_LOAD); else passed++;
      load_round(8'hAC); answer(8'h00, 1'b0, 1'b1); step();
      total++;
      if (highScore !== 8'd255) $display("FAIL sat_high: hi %0d, want 255", highScore); else passed++;
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss_lives();
      test_over();
      test_highscore();
      test_select_quit();
      test_reset_mid();
      test_timer();
      test_saturate();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
